// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader.
//   out_valid/out_ready : beat handshake
//   out_data            : captured register value
//   out_index           : register index of out_data
//   out_last            : marks the beat for the last index of the walk
interface regfile_dump_reader_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  // Reader side drives the beat, sink side drives ready.
  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks register indices FIRST..LAST through one registered register-file
// read port and streams each value out over a valid/ready interface.
//   cclk, rstb : clock, synchronous active-low reset
//   start      : dump request, honoured only while idle
//   busy, done : dump in progress / one-cycle completion pulse
//   rd_addr    : register-file read address (0 while idle)
//   rd_data    : register-file read data, one cycle after rd_addr
//   out_if     : beat stream (data, index, last) with valid/ready
module regfile_dump_reader #(
  parameter int unsigned FIRST = 0,
  parameter int unsigned LAST  = 31
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  regfile_dump_reader_if.master out_if
);
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_CAPT = 2'd2,
    S_SEND = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic [IDX_W-1:0]  rd_addr_q, rd_addr_d;

  logic handshake_c;
  logic at_last_c;

  assign handshake_c = (state_q == S_SEND) && out_valid_q && out_if.out_ready;
  assign at_last_c   = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADDR;
      S_ADDR:  state_d = S_CAPT;
      S_CAPT:  state_d = S_SEND;
      S_SEND:  if (handshake_c) state_d = at_last_c ? S_IDLE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are derived from the next state
  // so that every output is a flop with no path from start or out_ready.
  always_comb begin
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    case (state_q)
      S_IDLE: idx_d = FIRST_IDX;
      S_CAPT: begin
        // Read data for idx_q arrives here, one cycle after the ADDR cycle.
        out_data_d  = rd_data;
        out_index_d = idx_q;
      end
      S_SEND: if (handshake_c && !at_last_c) idx_d = idx_q + IDX_W'(1);
      default: ;
    endcase
    busy_d      = (state_d != S_IDLE);
    done_d      = handshake_c && at_last_c;
    out_valid_d = (state_d == S_SEND);
    out_last_d  = (state_d == S_SEND) && (idx_d == LAST_IDX);
    rd_addr_d   = (state_d != S_IDLE) ? idx_d : '0;
  end

  // Output and index registers
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      idx_q       <= FIRST_IDX;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      rd_addr_q   <= '0;
    end else begin
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign rd_addr          = rd_addr_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_last  = out_last_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        cclk = 1'b0;
  logic        rstb;
  logic        start_a, start_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;

  regfile_dump_reader_if if_a ();
  regfile_dump_reader_if if_b ();

  always #5 cclk = ~cclk;

  regfile_dump_reader u_dut_a (
    .cclk    (cclk),
    .rstb    (rstb),
    .start   (start_a),
    .busy    (busy_a),
    .done    (done_a),
    .rd_addr (rd_addr_a),
    .rd_data (rd_data_a),
    .out_if  (if_a)
  );

  regfile_dump_reader #(.FIRST(29), .LAST(31)) u_dut_b (
    .cclk    (cclk),
    .rstb    (rstb),
    .start   (start_b),
    .busy    (busy_b),
    .done    (done_b),
    .rd_addr (rd_addr_b),
    .rd_data (rd_data_b),
    .out_if  (if_b)
  );

  assign if_b.out_ready = 1'b1;

  // Register file model: registered read, write visible from the next edge.
  logic [31:0] rf [NREG];
  logic [31:0] shadow [NREG];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always @(posedge cclk) begin
    rd_data_a <= rf[rd_addr_a];
    rd_data_b <= rf[rd_addr_b];
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  int cyc = 0;
  always @(posedge cclk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state for instance A
  beat_t q_a [$];
  int    t0_a = 0, beat_k_a = 0, stalls_a = 0, done_due_a = -1, n_done_a = 0;
  bit    held_v_a = 0;
  beat_t held_a;

  // Scoreboard state for instance B
  beat_t q_b [$];
  int    t0_b = 0, beat_k_b = 0, n_done_b = 0;

  // Ready driver for A
  int ready_mode = 0;
  int ph = 0;
  always @(posedge cclk) begin
    #1;
    ph = (ph + 1) % 3;
    case (ready_mode)
      0: if_a.out_ready = 1'b1;
      1: if_a.out_ready = (ph == 0);
      2: if_a.out_ready = ($urandom_range(0, 1) == 1);
      default: if_a.out_ready = !(if_a.out_valid && if_a.out_index == 5'd7);
    endcase
  end

  // Monitor A
  always @(negedge cclk) begin
    beat_t e;
    if (rstb) begin
      if (if_a.out_valid) begin
        if (held_v_a) begin
          chk("a_stall_data",  if_a.out_data, held_a.data);
          chk("a_stall_index", 32'(if_a.out_index), 32'(held_a.idx));
          chk("a_stall_last",  32'(if_a.out_last), 32'(held_a.last));
        end
        if (if_a.out_ready) begin
          if (q_a.size() == 0) begin
            chk("a_unexpected_beat", 32'(if_a.out_index), 32'hFFFF_FFFF);
          end else begin
            e = q_a.pop_front();
            chk("a_index", 32'(if_a.out_index), 32'(e.idx));
            chk("a_data",  if_a.out_data, e.data);
            chk("a_last",  32'(if_a.out_last), 32'(e.last));
            chk("a_beat_cycle", 32'(cyc - t0_a), 32'(3 * (beat_k_a + 1) + stalls_a));
            beat_k_a++;
            if (e.last) done_due_a = cyc + 1;
          end
          held_v_a = 0;
        end else begin
          stalls_a++;
          held_v_a   = 1;
          held_a.idx = if_a.out_index;
          held_a.data = if_a.out_data;
          held_a.last = if_a.out_last;
        end
      end else begin
        chk("a_last_idle", 32'(if_a.out_last), 32'd0);
      end
      if (done_a) begin
        n_done_a++;
        chk("a_done_cycle", 32'(cyc), 32'(done_due_a));
        chk("a_busy_at_done", 32'(busy_a), 32'd0);
      end
    end else begin
      held_v_a = 0;
    end
  end

  // Monitor B (sub-range instance, ready tied high)
  always @(negedge cclk) begin
    beat_t e;
    if (rstb) begin
      if (if_b.out_valid) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_beat", 32'(if_b.out_index), 32'hFFFF_FFFF);
        end else begin
          e = q_b.pop_front();
          chk("b_index", 32'(if_b.out_index), 32'(e.idx));
          chk("b_data",  if_b.out_data, e.data);
          chk("b_last",  32'(if_b.out_last), 32'(e.last));
          chk("b_beat_cycle", 32'(cyc - t0_b), 32'(3 * (beat_k_b + 1)));
          beat_k_b++;
        end
      end
      if (done_b) begin
        n_done_b++;
        chk("b_done_cycle", 32'(cyc - t0_b), 32'd10);
        chk("b_busy_at_done", 32'(busy_b), 32'd0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge cclk);
      #1;
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; shadow[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  // Expected stream for a full 0..31 dump; an optional planned write is
  // folded in because it lands before that register is captured.
  task automatic start_a_dump(input logic [4:0] ov_addr, input logic [31:0] ov_data, input bit ov);
    beat_t b;
    t0_a = cyc; beat_k_a = 0; stalls_a = 0; held_v_a = 0;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = (ov && 5'(i) == ov_addr) ? ov_data : shadow[i];
      b.last = (i == 31);
      q_a.push_back(b);
    end
    start_a = 1'b1;
  endtask

  task automatic wait_done_a(input int budget);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    if (done_a !== 1'b1) chk("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_a_idx(input logic [4:0] k, input int budget);
    int n;
    n = 0;
    while (!(if_a.out_valid && if_a.out_index == k) && n < budget) begin
      step();
      n++;
    end
    chk("a_reached_idx", 32'(if_a.out_valid && if_a.out_index == k), 32'd1);
  endtask

  initial begin
    int nd;
    beat_t b;
    rstb = 1'b0; start_a = 1'b0; start_b = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(3);
    rstb = 1'b1;
    step(5);

    // Reset values
    chk("rst_busy",      32'(busy_a), 32'd0);
    chk("rst_done",      32'(done_a), 32'd0);
    chk("rst_rd_addr",   32'(rd_addr_a), 32'd0);
    chk("rst_valid",     32'(if_a.out_valid), 32'd0);
    chk("rst_last",      32'(if_a.out_last), 32'd0);
    chk("rst_data",      if_a.out_data, 32'd0);
    chk("rst_index",     32'(if_a.out_index), 32'd0);
    chk("rst_b_busy",    32'(busy_b), 32'd0);
    chk("rst_b_valid",   32'(if_b.out_valid), 32'd0);
    chk("rst_b_rd_addr", 32'(rd_addr_b), 32'd0);

    for (int i = 0; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 + 32'(i));

    // Full dump, ready high
    ready_mode = 0;
    start_a_dump('0, '0, 0);
    step(); start_a = 1'b0;
    wait_done_a(200);
    step(3);
    chk("full_drained", 32'(q_a.size()), 32'd0);

    // Backpressure 1,0,0 pattern
    ready_mode = 1;
    start_a_dump('0, '0, 0);
    step(); start_a = 1'b0;
    wait_done_a(400);
    step(3);
    chk("bp_drained", 32'(q_a.size()), 32'd0);

    // Sub-range 29..31 on instance B
    t0_b = cyc; beat_k_b = 0;
    for (int i = 29; i < 32; i++) begin
      b.idx = 5'(i); b.data = shadow[i]; b.last = (i == 31);
      q_b.push_back(b);
    end
    start_b = 1'b1;
    step(); start_b = 1'b0;
    step(15);
    chk("b_drained", 32'(q_b.size()), 32'd0);
    chk("b_done_count", 32'(n_done_b), 32'd1);

    // Random contents with random backpressure
    for (int i = 0; i < 32; i++) do_write(5'(i), $urandom);
    ready_mode = 2;
    start_a_dump('0, '0, 0);
    step(); start_a = 1'b0;
    wait_done_a(1000);
    step(3);
    chk("rand_drained", 32'(q_a.size()), 32'd0);

    // Reset while the index-7 beat is stalled
    ready_mode = 3;
    nd = n_done_a;
    start_a_dump('0, '0, 0);
    step(); start_a = 1'b0;
    wait_a_idx(5'd7, 200);
    rstb = 1'b0;
    step();
    q_a.delete();
    chk("mid_rst_valid", 32'(if_a.out_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy_a), 32'd0);
    chk("mid_rst_done",  32'(done_a), 32'd0);
    chk("mid_rst_index", 32'(if_a.out_index), 32'd0);
    chk("mid_rst_addr",  32'(rd_addr_a), 32'd0);
    rstb = 1'b1;
    step(5);
    chk("mid_rst_no_done", 32'(n_done_a - nd), 32'd0);
    ready_mode = 0;
    start_a_dump('0, '0, 0);
    step(); start_a = 1'b0;
    wait_done_a(200);
    step(3);
    chk("restart_drained", 32'(q_a.size()), 32'd0);

    // Concurrent write to reg 20 at idx 10, plus ignored start pulses
    nd = n_done_a;
    start_a_dump(5'd20, 32'hDEAD_BEEF, 1);
    step(); start_a = 1'b0;
    wait_a_idx(5'd10, 100);
    do_write(5'd20, 32'hDEAD_BEEF);
    repeat (3) begin
      if (busy_a) start_a = 1'b1;
      step(); start_a = 1'b0;
      step();
    end
    wait_done_a(200);
    step(5);
    chk("cw_single_done", 32'(n_done_a - nd), 32'd1);
    chk("cw_drained", 32'(q_a.size()), 32'd0);

    // Back-to-back dumps with start held high
    nd = n_done_a;
    start_a_dump('0, '0, 0);
    step();
    wait_done_a(200);
    start_a_dump('0, '0, 0);
    step(); start_a = 1'b0;
    wait_done_a(200);
    step(3);
    chk("b2b_done_count", 32'(n_done_a - nd), 32'd2);
    chk("b2b_drained", 32'(q_a.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end
endmodule
